// File: rtl/glyph_pkg.sv
// Shared types and glyph bitmaps for the glyph plotter.
// GLYPHS[sym][row][col]: bit col of a row word is the pixel at that column.
package glyph_pkg;

    localparam int GLYPH_N = 4;
    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } glyph_state_e;

    localparam logic [GLYPH_W-1:0] GLYPHS [GLYPH_N][GLYPH_H] = '{
        // 0: one-pixel outline
        '{16'hFFFF, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001,
          16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'hFFFF},
        // 1: solid block
        '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
          16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
        // 2: invader
        '{16'h0000, 16'h0810, 16'h0420, 16'h0FF0, 16'h1BD8, 16'h3FFC, 16'h2FF4, 16'h2814,
          16'h0660, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        // 3: diamond
        '{16'h0180, 16'h03C0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h3FFC, 16'h7FFE, 16'hFFFF,
          16'hFFFF, 16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h0FF0, 16'h07E0, 16'h03C0, 16'h0180}
    };

endpackage

// File: rtl/glyph_plotter_if.sv
// Request/pixel bundle between game control (master) and the plotter (slave).
interface glyph_plotter_if #(
    parameter int SYM_W = 2,
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int COL_W = 3
);
    import glyph_pkg::*;

    // Handshake: start is a one-cycle request honoured only while the plotter
    // is idle (busy=0, done=0); busy is high for every scan cycle and done
    // pulses for one cycle afterwards. A start seen while busy or in the done
    // cycle is dropped, never queued.
    logic             start;
    logic [SYM_W-1:0] sym_sel;
    logic [X_W-1:0]   x_in;
    logic [Y_W-1:0]   y_in;
    logic [COL_W-1:0] colour_in;
    logic             erase;

    logic [X_W-1:0]   xout;
    logic [Y_W-1:0]   yout;
    logic [COL_W-1:0] colour;
    logic             plot;
    logic             busy;
    logic             done;
    glyph_state_e     state_dbg;

    modport master (
        output start, sym_sel, x_in, y_in, colour_in, erase,
        input  xout, yout, colour, plot, busy, done, state_dbg
    );

    modport slave (
        input  start, sym_sel, x_in, y_in, colour_in, erase,
        output xout, yout, colour, plot, busy, done, state_dbg
    );

endinterface

// File: rtl/glyph_rom.sv
// Combinational glyph bitmap lookup; out-of-range symbols fall back to glyph 0.
module glyph_rom
    import glyph_pkg::*;
#(
    parameter int NUM_SYM = 4,
    parameter int SYM_W   = 2,
    parameter int RW      = 4,
    parameter int CW      = 4
) (
    input  logic [SYM_W-1:0] sym,
    input  logic [RW-1:0]    row,
    input  logic [CW-1:0]    col,
    output logic             pix
);

    logic [SYM_W-1:0] sym_eff;

    always_comb begin
        sym_eff = sym;
        if (32'(sym) >= 32'(NUM_SYM)) begin
            sym_eff = '0;
        end
        pix = GLYPHS[sym_eff][row][col];
    end

endmodule

// File: rtl/glyph_plotter.sv
// Scans one W x H glyph at a latched base coordinate, one pixel per clock,
// with erase mode and clipping at the right/bottom screen edges.
module glyph_plotter
    import glyph_pkg::*;
#(
    parameter int              W         = 16,
    parameter int              H         = 16,
    parameter int              NUM_SYM   = 4,
    parameter int              X_W       = 8,
    parameter int              Y_W       = 7,
    parameter int              COL_W     = 3,
    parameter int              X_MAX     = 160,
    parameter int              Y_MAX     = 120,
    parameter logic [COL_W-1:0] BG_COLOUR = 3'b000
) (
    input logic             clock,
    input logic             reset_n,
    glyph_plotter_if.slave  bus
);

    localparam int SYM_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam int CW    = $clog2(W);
    localparam int RW    = $clog2(H);

    glyph_state_e     state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic [X_W-1:0]   xb_q, xb_d;
    logic [Y_W-1:0]   yb_q, yb_d;
    logic [COL_W-1:0] fg_q, fg_d;
    logic             erase_q, erase_d;

    logic             pix;
    logic [X_W:0]     x_sum;
    logic [Y_W:0]     y_sum;
    logic             scanning;
    logic             pix_on;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        sym_d   = sym_q;
        xb_d    = xb_q;
        yb_d    = yb_q;
        fg_d    = fg_q;
        erase_d = erase_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sym_d   = bus.sym_sel;
                    xb_d    = bus.x_in;
                    yb_d    = bus.y_in;
                    fg_d    = bus.colour_in;
                    erase_d = bus.erase;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // W and H are powers of two, so the counters wrap back to 0 on their own.
                col_d = col_q + 1'b1;
                if (col_q == CW'(W - 1)) begin
                    row_d = row_q + 1'b1;
                    if (row_q == RW'(H - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            sym_q   <= '0;
            xb_q    <= '0;
            yb_q    <= '0;
            fg_q    <= '0;
            erase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sym_q   <= sym_d;
            xb_q    <= xb_d;
            yb_q    <= yb_d;
            fg_q    <= fg_d;
            erase_q <= erase_d;
        end
    end

    glyph_rom #(
        .NUM_SYM (NUM_SYM),
        .SYM_W   (SYM_W),
        .RW      (RW),
        .CW      (CW)
    ) u_rom (
        .sym (sym_q),
        .row (row_q),
        .col (col_q),
        .pix (pix)
    );

    // Sums carry one extra bit so a pixel past the coordinate range still clips.
    assign x_sum    = {1'b0, xb_q} + (X_W + 1)'(col_q);
    assign y_sum    = {1'b0, yb_q} + (Y_W + 1)'(row_q);
    assign scanning = (state_q == SCAN);
    assign pix_on   = (erase_q | pix) & (x_sum < (X_W + 1)'(X_MAX)) & (y_sum < (Y_W + 1)'(Y_MAX));

    assign bus.plot      = scanning & pix_on;
    assign bus.xout      = scanning ? x_sum[X_W-1:0] : '0;
    assign bus.yout      = scanning ? y_sum[Y_W-1:0] : '0;
    assign bus.colour    = bus.plot ? (erase_q ? BG_COLOUR : fg_q) : '0;
    assign bus.busy      = scanning;
    assign bus.done      = (state_q == DONE);
    assign bus.state_dbg = state_q;

endmodule
